// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl_pkg : shared types/constants for the hazard control |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pipe_hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_FPWAIT = 1'b1
  } state_t;

  localparam logic [1:0] WBSRC_MEM      = 2'b01;
  localparam int         FP_LAT_DEFAULT = 4;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_cmp : load-use hazard comparator between ID and EX       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rs,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_rwrite,
  input  logic [1:0] i_ex_wbsrc,
  input  logic [4:0] i_ex_dst,
  output logic       o_ld_hz
);

  logic w_ex_is_load;
  logic w_src_match;

  // r0 is hardwired zero, so a load into it never creates a dependency
  assign w_ex_is_load = i_ex_rwrite && (i_ex_wbsrc == WBSRC_MEM) && (i_ex_dst != 5'd0);
  assign w_src_match  = (i_id_uses_rs && (i_id_rs == i_ex_dst)) ||
                        (i_id_uses_rt && (i_id_rt == i_ex_dst));
  assign o_ld_hz      = w_ex_is_load && i_id_valid && w_src_match;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/flush control for load-use, branch, float   |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FP_LAT = FP_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_float,
  input  logic        ex_rwrite,
  input  logic [1:0]  ex_wbsrc,
  input  logic [4:0]  ex_dst,
  input  logic        ex_branch_taken,
  input  logic        cnt_clr,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        fp_start,
  output logic        fp_done,
  output logic        fp_busy,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] c_LAT_LOAD = 4'(FP_LAT - 1);

  state_t      r_state;
  logic [3:0]  r_lat_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_ld_hz;

  pipe_hazard_cmp u_cmp (
    .i_id_valid   (id_valid),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .i_id_uses_rs (id_uses_rs),
    .i_id_uses_rt (id_uses_rt),
    .i_ex_rwrite  (ex_rwrite),
    .i_ex_wbsrc   (ex_wbsrc),
    .i_ex_dst     (ex_dst),
    .o_ld_hz      (w_ld_hz)
  );

  // Outputs are gated by rst_n so the pipeline sees a clean "run" while held in reset
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    fp_start    = 1'b0;
    fp_done     = 1'b0;
    fp_busy     = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (w_ld_hz) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
          end else if (id_valid && id_float) begin
            fp_start    = 1'b1;
          end
        end
        ST_FPWAIT: begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          fp_busy     = 1'b1;
          fp_done     = (r_lat_cnt == 4'd1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_lat_cnt   <= 4'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (fp_start) begin
            r_state   <= ST_FPWAIT;
            r_lat_cnt <= c_LAT_LOAD;
          end
        end
        ST_FPWAIT: begin
          r_lat_cnt <= r_lat_cnt - 4'd1;
          if (r_lat_cnt == 4'd1) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase

      if (cnt_clr)
        r_stall_cnt <= 16'd0;
      else if (!pc_en && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : scoreboard bench for pipe_hazard_ctrl          |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  // {pc_en, ifid_en, ifid_flush, idex_bubble, fp_start, fp_done, fp_busy}
  localparam logic [6:0] c_NORMAL = 7'b1100000;
  localparam logic [6:0] c_LDSTL  = 7'b0001000;
  localparam logic [6:0] c_BRANCH = 7'b1111000;
  localparam logic [6:0] c_FPSTRT = 7'b1100100;
  localparam logic [6:0] c_FPWAIT = 7'b0001001;
  localparam logic [6:0] c_FPDONE = 7'b0001011;

  typedef struct packed {
    logic [6:0]  ctrl;
    logic [15:0] stall;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_uses_rs, id_uses_rt, id_float;
  logic [4:0]  id_rs, id_rt, ex_dst;
  logic        ex_rwrite, ex_branch_taken, cnt_clr;
  logic [1:0]  ex_wbsrc;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, fp_start, fp_done, fp_busy;
  logic [15:0] stall_cnt;

  exp_t        r_sb_q[$];
  logic [15:0] r_exp_stall;
  int          n_checks = 0;
  int          n_pass   = 0;

  pipe_hazard_ctrl #(.FP_LAT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_float        (id_float),
    .ex_rwrite       (ex_rwrite),
    .ex_wbsrc        (ex_wbsrc),
    .ex_dst          (ex_dst),
    .ex_branch_taken (ex_branch_taken),
    .cnt_clr         (cnt_clr),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .fp_start        (fp_start),
    .fp_done         (fp_done),
    .fp_busy         (fp_busy),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Queue the expectation, compare on the falling edge, then advance one clock
  task automatic cyc(input string tag, input logic [6:0] ctrl);
    exp_t e;
    r_sb_q.push_back('{ctrl: ctrl, stall: r_exp_stall});
    @(negedge clk);
    e = r_sb_q.pop_front();
    check_eq({tag, ".ctrl"}, {25'd0, pc_en, ifid_en, ifid_flush, idex_bubble,
                              fp_start, fp_done, fp_busy}, {25'd0, e.ctrl});
    check_eq({tag, ".stall"}, {16'd0, stall_cnt}, {16'd0, e.stall});
    @(posedge clk);
    #1;
    if (!rst_n || cnt_clr)                       r_exp_stall = 16'd0;
    else if (!ctrl[6] && r_exp_stall != 16'hFFFF) r_exp_stall = r_exp_stall + 16'd1;
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_float = 1'b0; ex_rwrite = 1'b0; ex_wbsrc = 2'b00; ex_dst = 5'd0;
    ex_branch_taken = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic set_load_hz(input logic [4:0] dst);
    id_valid = 1'b1; id_uses_rs = 1'b1; id_rs = dst;
    ex_rwrite = 1'b1; ex_wbsrc = 2'b01; ex_dst = dst;
  endtask

  initial begin
    rst_n = 1'b0;
    r_exp_stall = 16'd0;
    idle_inputs();
    // Hostile inputs during reset must not leak through
    set_load_hz(5'd7);
    ex_branch_taken = 1'b1;
    id_float = 1'b1;
    cyc("reset", c_NORMAL);
    rst_n = 1'b1;
    idle_inputs();
    cyc("idle", c_NORMAL);

    // Load-use on rs, then the bubble leaves EX
    set_load_hz(5'd5);
    cyc("ld_rs", c_LDSTL);
    ex_rwrite = 1'b0;
    cyc("ld_after", c_NORMAL);
    check_eq("ld_cnt", {16'd0, stall_cnt}, 32'd1);

    // Load-use through rt only
    idle_inputs();
    set_load_hz(5'd9);
    id_uses_rs = 1'b0; id_uses_rt = 1'b1; id_rt = 5'd9; id_rs = 5'd3;
    cyc("ld_rt", c_LDSTL);

    // Non-hazards
    set_load_hz(5'd0);
    cyc("ld_r0", c_NORMAL);
    set_load_hz(5'd5); id_uses_rs = 1'b0;
    cyc("ld_unused", c_NORMAL);
    set_load_hz(5'd5); ex_wbsrc = 2'b00;
    cyc("alu_wb", c_NORMAL);
    set_load_hz(5'd5); id_valid = 1'b0;
    cyc("id_invalid", c_NORMAL);
    set_load_hz(5'd5); id_rs = 5'd6;
    cyc("ld_other", c_NORMAL);

    // Branch beats load hazard and float issue
    set_load_hz(5'd5); ex_branch_taken = 1'b1; id_float = 1'b1;
    cyc("br_ld", c_BRANCH);
    idle_inputs();

    // Float op, hazards/branches ignored while waiting, back-to-back issue
    id_valid = 1'b1; id_float = 1'b1;
    cyc("fp0", c_FPSTRT);
    cyc("fp1", c_FPWAIT);
    set_load_hz(5'd4); ex_branch_taken = 1'b1;
    cyc("fp2", c_FPWAIT);
    cyc("fp3", c_FPDONE);
    idle_inputs(); id_valid = 1'b1; id_float = 1'b1;
    cyc("fpb2b0", c_FPSTRT);
    id_float = 1'b0;
    cyc("fpb2b1", c_FPWAIT);
    cyc("fpb2b2", c_FPWAIT);
    cyc("fpb2b3", c_FPDONE);
    cyc("fp_run", c_NORMAL);

    // Reset in the second wait cycle aborts the float op
    idle_inputs(); id_valid = 1'b1; id_float = 1'b1;
    cyc("fpr0", c_FPSTRT);
    id_float = 1'b0;
    cyc("fpr1", c_FPWAIT);
    rst_n = 1'b0;
    r_exp_stall = 16'd0;
    cyc("fpr_rst", c_NORMAL);
    rst_n = 1'b1;
    cyc("fpr_after0", c_NORMAL);
    cyc("fpr_after1", c_NORMAL);
    cyc("fpr_after2", c_NORMAL);

    // Saturation: hold a load hazard for 65535 cycles
    idle_inputs();
    set_load_hz(5'd12);
    repeat (65535) begin
      @(posedge clk);
      #1;
      if (r_exp_stall != 16'hFFFF) r_exp_stall = r_exp_stall + 16'd1;
    end
    cyc("sat_hold", c_LDSTL);
    cyc("sat_still", c_LDSTL);
    cnt_clr = 1'b1;
    cyc("clr_vs_stall", c_LDSTL);
    cnt_clr = 1'b0;
    idle_inputs();
    cyc("after_clr", c_NORMAL);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
